// File: rtl/audio_pkg.sv
// Shared definitions for the serial audio blocks.
// Mode and FSM encodings plus a width helper.
package audio_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_TDM = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD,
    WAIT
  } tx_state_t;

  // Counter width for values 0..v-1, never below 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/lrck_sync.sv
// LRCK delay flops and slot/frame start decode.
// Ports: sclk_in, rst, lrck_in -> frame_start_p, slot_start_p, chan_sel.
module lrck_sync
  import audio_pkg::*;
#(
  parameter int mode = MODE_I2S
) (
  input  logic sclk_in,
  input  logic rst,
  input  logic lrck_in,
  output logic frame_start_p,
  output logic slot_start_p,
  output logic chan_sel
);

  logic lrck_d1;
  logic lrck_d2;
  logic lrck_edge;

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      lrck_d1 <= 1'b0;
      lrck_d2 <= 1'b0;
    end else begin
      lrck_d1 <= lrck_in;
      lrck_d2 <= lrck_d1;
    end
  end

  assign lrck_edge = lrck_d1 ^ lrck_d2;

  // I2S: falling edge opens ch0, any edge opens a slot.
  // TDM: only the rising edge matters.
  assign frame_start_p = lrck_edge &
    ((mode == MODE_TDM) ? lrck_d1 : ~lrck_d1);

  assign slot_start_p = (mode == MODE_TDM) ?
    frame_start_p : lrck_edge;

  assign chan_sel = lrck_d1;

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serial audio transmitter, clock and sync slave.
// Ports: sclk_in, rst, lrck_in, pdata_in/pvalid_in/pready_out,
//        sdata_out, underrun_out, frame_err_out.
module i2s_tdm_tx
  import audio_pkg::*;
#(
  parameter int sample_width = 24,
  parameter int slot_width   = 32,
  parameter int channels     = 2,
  parameter int mode         = MODE_I2S
) (
  input  logic                               sclk_in,
  input  logic                               rst,
  input  logic                               lrck_in,
  input  logic [channels*sample_width-1:0]   pdata_in,
  input  logic                               pvalid_in,
  output logic                               pready_out,
  output logic                               sdata_out,
  output logic                               underrun_out,
  output logic                               frame_err_out
);

  localparam int FW = channels * sample_width;
  localparam int BW = clog2(slot_width);
  localparam int CW = clog2(channels);

  localparam logic [BW-1:0] BIT_LAST  = BW'(slot_width - 1);
  localparam logic [BW-1:0] SAMP_LAST = BW'(sample_width - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(channels - 1);
  localparam logic          TDM       = (mode == MODE_TDM);

  logic frame_start_p;
  logic slot_start_p;
  logic chan_sel;

  lrck_sync #(
    .mode(mode)
  ) u_sync (
    .sclk_in      (sclk_in),
    .rst          (rst),
    .lrck_in      (lrck_in),
    .frame_start_p(frame_start_p),
    .slot_start_p (slot_start_p),
    .chan_sel     (chan_sel)
  );

  logic [FW-1:0] buf_q;
  logic          buf_full_q;
  logic [FW-1:0] act_q;
  logic [FW-1:0] act_n;
  tx_state_t     state_q;
  tx_state_t     state_n;
  logic [BW-1:0] bit_q;
  logic [BW-1:0] bit_n;
  logic [CW-1:0] ch_q;
  logic [CW-1:0] ch_n;
  logic          xfer;
  logic          in_flight;
  logic          slot_end;
  logic          frame_done;
  logic          unr_n;
  logic          err_n;
  logic          sd_bit;
  logic          sd_n;

  assign pready_out = ~buf_full_q;
  assign xfer       = pvalid_in & ~buf_full_q;

  // The registers describe the bit currently on sdata_out.
  // The counter runs through SHIFT and PAD, so the last
  // bit of a slot is always bit_q == BIT_LAST.
  assign in_flight  = (state_q == SHIFT) || (state_q == PAD);
  assign slot_end   = in_flight && (bit_q == BIT_LAST);
  assign frame_done = (bit_q == BIT_LAST) &&
                      (!TDM || (ch_q == CH_LAST));

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    ch_n    = ch_q;
    act_n   = act_q;
    unr_n   = 1'b0;
    err_n   = 1'b0;
    if (frame_start_p) begin
      state_n = SHIFT;
      bit_n   = '0;
      ch_n    = '0;
      act_n   = buf_full_q ? buf_q : '0;
      unr_n   = ~buf_full_q;
      err_n   = in_flight && !frame_done;
    end else if (slot_start_p && (state_q != IDLE)) begin
      // Only reachable in I2S: the rising edge opens ch1.
      state_n = SHIFT;
      bit_n   = '0;
      ch_n    = CW'(chan_sel);
      err_n   = in_flight && !frame_done;
    end else if (slot_end) begin
      bit_n = '0;
      if (TDM && (ch_q != CH_LAST)) begin
        state_n = SHIFT;
        ch_n    = ch_q + CW'(1);
      end else begin
        state_n = WAIT;
      end
    end else if (in_flight) begin
      bit_n = bit_q + BW'(1);
      if ((state_q == SHIFT) && (bit_q == SAMP_LAST))
        state_n = PAD;
    end
  end

  // Bit select from the next active frame, MSB first.
  always_comb begin
    sd_bit = 1'b0;
    for (int c = 0; c < channels; c++)
      for (int b = 0; b < sample_width; b++)
        if ((ch_n == CW'(c)) && (bit_n == BW'(b)))
          sd_bit = act_n[c*sample_width + sample_width - 1 - b];
  end

  assign sd_n = (state_n == SHIFT) && sd_bit;

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_q         <= '0;
      ch_q          <= '0;
      act_q         <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      sdata_out     <= 1'b0;
      underrun_out  <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      state_q       <= state_n;
      bit_q         <= bit_n;
      ch_q          <= ch_n;
      act_q         <= act_n;
      sdata_out     <= sd_n;
      underrun_out  <= unr_n;
      frame_err_out <= err_n;
      // A full buffer blocks xfer, so the two never collide.
      if (frame_start_p && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (xfer) begin
        buf_full_q <= 1'b1;
        buf_q      <= pdata_in;
      end
    end
  end

endmodule
